pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Consumer side of the load-use hazard signal: turns the hazard detector's raw stall request, the branch-taken redirect and the data-memory busy signal into per-stage pipeline enables, flushes and bubbles for the 5-stage core. Guarantees exactly one bubble per load-use hazard and correct flush ordering when the pipeline is frozen. Keeps saturating performance counters for stall, flush and freeze cycles. Sits beside the hazard detector and drives the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous, active-high reset.
stall_req  in  1  load-use hazard request from the hazard detector.
branch_taken  in  1  taken branch/jump resolved in MEM; younger instructions must be flushed.
mem_busy  in  1  data memory not ready; the whole pipeline freezes.
pc_we  out  1  PC write enable.
if_id_we  out  1  IF/ID register write enable.
if_id_flush  out  1  clear IF/ID to NOP.
id_ex_bubble  out  1  load NOP controls into ID/EX.
ex_mem_flush  out  1  clear EX/MEM to NOP.
stall_cnt  out  CNT_W  cycles spent in a load-use stall.
flush_cnt  out  CNT_W  flush events applied.
freeze_cnt  out  CNT_W  cycles frozen by mem_busy.

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- State register with four states: RUN, STALL, FREEZE, FLUSH_PEND.
- While rst is high: state goes to RUN, pending flush clears and all counters clear to 0. Outputs during reset: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. The pipeline is held empty.
- Output decode is combinational from the current state and inputs, evaluated in this priority order:
  1. mem_busy=1: all enables are 0 and all flushes/bubble are 0 (hold). If branch_taken is also 1, set the pending flag. Next state is FREEZE, or FLUSH_PEND if a flush is pending.
  2. branch_taken=1, or the pending flag is set with mem_busy=0: pc_we=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1. Clear the pending flag. Next state is RUN. A simultaneous stall_req is dropped.
  3. stall_req=1 and state is RUN: pc_we=0, if_id_we=0, id_ex_bubble=1. Next state is STALL.
  4. Otherwise: pc_we=1, if_id_we=1, no flush. Next state is RUN.
- In STALL, stall_req is ignored for one cycle, even if still asserted. This blocks a double bubble caused by a stale request; the cycle behaves as case 4. The result is exactly one bubble per load-use.
- FREEZE / FLUSH_PEND: leaving a freeze takes zero extra cycles. The first cycle with mem_busy=0 applies the pending flush if there is one, otherwise normal RUN decode.
- Reset mid-freeze or mid-stall discards the pending flush and any stall.
- Counters:
  - stall_cnt increments on each case-3 cycle.
  - flush_cnt increments on each case-2 cycle.
  - freeze_cnt increments on each case-1 cycle.
  - All saturate at all-ones and do not wrap.
- Latency: all control outputs respond in the same cycle as the inputs. Counters update at the next clock edge.

Decomposition:
- Package pipe_ctrl_pkg: state encoding constants (RUN, STALL, FREEZE, FLUSH_PEND), state width, default CNT_W.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated three times for the counters.

Test Plan:
- rst held 2 cycles, then released with no requests -> during reset pc_we=0 and all flushes=1; after release pc_we=1, if_id_we=1, all counters=0.
- stall_req held high for 2 consecutive cycles -> cycle 1: pc_we=0, if_id_we=0, id_ex_bubble=1; cycle 2: pc_we=1, no bubble. stall_cnt=1.
- branch_taken and stall_req high in the same cycle -> if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_we=1. Next cycle RUN. flush_cnt=1, stall_cnt=0.
- mem_busy high 3 cycles with branch_taken pulsed in busy cycle 2 -> 3 hold cycles with all outputs 0. First non-busy cycle applies the flush. freeze_cnt=3, flush_cnt=1.
- rst asserted during a freeze with a pending flush -> after release no flush is applied and counters=0.
- CNT_W=4 and 20 stall events separated by idle cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    FREEZE     = 2'd2,
    FLUSH_PEND = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, clear on reset, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns load-use stall requests, branch redirects and memory-busy into
// per-stage enables, flushes and bubbles, with saturating event counters.
import pipe_ctrl_pkg::*;

module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        r_pend;
  logic        w_pend_next;
  logic        w_do_freeze;
  logic        w_do_flush;
  logic        w_do_stall;

  // Priority decode: freeze > flush (new or pending) > stall > run.
  // The stall arm is blocked in STALL so a stale request cannot add a second bubble.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_do_freeze  = 1'b0;
    w_do_flush   = 1'b0;
    w_do_stall   = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      w_state_next = RUN;
      w_pend_next  = 1'b0;
    end else if (mem_busy) begin
      w_do_freeze  = 1'b1;
      w_pend_next  = r_pend | branch_taken;
      w_state_next = w_pend_next ? FLUSH_PEND : FREEZE;
    end else if (branch_taken || r_pend) begin
      pc_we        = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      w_pend_next  = 1'b0;
      w_state_next = RUN;
      w_do_flush   = 1'b1;
    end else if (stall_req && (r_state != STALL)) begin
      id_ex_bubble = 1'b1;
      w_state_next = STALL;
      w_do_stall   = 1'b1;
    end else begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      w_state_next = RUN;
    end
  end

  // State and pending-flush registers; reset discards any pending flush or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_do_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_do_flush),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_do_freeze),
    .count (freeze_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random
// traffic against a behavioural model, on a 32-bit and a 4-bit counter instance.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall_req, branch_taken, mem_busy;

  logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  logic        pc_we4, if_id_we4, if_id_flush4, id_ex_bubble4, ex_mem_flush4;
  logic [3:0]  stall_cnt4, flush_cnt4, freeze_cnt4;

  pipeline_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .freeze_cnt   (freeze_cnt)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we4),
    .if_id_we     (if_id_we4),
    .if_id_flush  (if_id_flush4),
    .id_ex_bubble (id_ex_bubble4),
    .ex_mem_flush (ex_mem_flush4),
    .stall_cnt    (stall_cnt4),
    .flush_cnt    (flush_cnt4),
    .freeze_cnt   (freeze_cnt4)
  );

  int checks = 0;
  int errors = 0;

  // Model: a pending-redirect flag, whether the previous cycle issued a
  // load-use bubble, and plain event counts.
  bit          m_pend     = 1'b0;
  bit          m_bubbled  = 1'b0;
  logic [31:0] m_st = '0, m_fl = '0, m_fr = '0;
  logic [3:0]  m4_st = '0, m4_fl = '0, m4_fr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // One clock cycle: apply inputs, check same-cycle controls and current
  // counters, then advance the model across the clock edge.
  task automatic step(input bit s, input bit b, input bit m, input bit r);
    logic [4:0] e;
    int         kind;
    stall_req = s; branch_taken = b; mem_busy = m; rst = r;
    #2;
    if (r)                     begin e = 5'b00111; kind = 0; end
    else if (m)                begin e = 5'b00000; kind = 1; end
    else if (b || m_pend)      begin e = 5'b10111; kind = 2; end
    else if (s && !m_bubbled)  begin e = 5'b00010; kind = 3; end
    else                       begin e = 5'b11000; kind = 4; end
    chk("ctrl32", {27'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush}, {27'd0, e});
    chk("ctrl4", {27'd0, pc_we4, if_id_we4, if_id_flush4, id_ex_bubble4, ex_mem_flush4}, {27'd0, e});
    chk("stall_cnt", stall_cnt, m_st);
    chk("flush_cnt", flush_cnt, m_fl);
    chk("freeze_cnt", freeze_cnt, m_fr);
    chk("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, m4_st});
    chk("flush_cnt4", {28'd0, flush_cnt4}, {28'd0, m4_fl});
    chk("freeze_cnt4", {28'd0, freeze_cnt4}, {28'd0, m4_fr});
    @(posedge clk);
    case (kind)
      0: begin
        m_pend = 1'b0; m_bubbled = 1'b0;
        m_st = '0; m_fl = '0; m_fr = '0; m4_st = '0; m4_fl = '0; m4_fr = '0;
      end
      1: begin
        if (b) m_pend = 1'b1;
        m_bubbled = 1'b0;
        m_fr = inc32(m_fr); m4_fr = inc4(m4_fr);
      end
      2: begin
        m_pend = 1'b0; m_bubbled = 1'b0;
        m_fl = inc32(m_fl); m4_fl = inc4(m4_fl);
      end
      3: begin
        m_bubbled = 1'b1;
        m_st = inc32(m_st); m4_st = inc4(m4_st);
      end
      default: m_bubbled = 1'b0;
    endcase
    #1;
  endtask

  initial begin
    stall_req = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Reset held two cycles, then idle.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_cnt_zero", stall_cnt | flush_cnt | freeze_cnt, 32'd0);

    // Stall request held for two cycles yields exactly one bubble.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("one_bubble", stall_cnt, 32'd1);

    // Branch and stall together: flush wins.
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("br_stall_flush", flush_cnt, 32'd1);
    chk("br_stall_nostall", stall_cnt, 32'd0);

    // Freeze three cycles with a branch in the second; flush lands on exit.
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("freeze_cnt3", freeze_cnt, 32'd3);
    chk("freeze_flush1", flush_cnt, 32'd1);

    // Reset during freeze drops the pending flush.
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_drop_flush", flush_cnt, 32'd0);
    chk("rst_drop_freeze", freeze_cnt, 32'd0);

    // Twenty separated stall events: 4-bit counter saturates.
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    chk("sat4_stall", {28'd0, stall_cnt4}, 32'd15);
    chk("sat32_stall", stall_cnt, 32'd20);

    // Random traffic against the model.
    step(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
